// File: rtl/truth_table_checker.sv
// Clocked exhaustive sweep: drives every input vector, compares two gate implementations, counts disagreeing rows.
// Optional TT_EXPECT_EN adds a golden truth-table input (expect_tbl) checked against dut_a.
module truth_table_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_a,
  input  logic            dut_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
`ifdef TT_EXPECT_EN
  ,
  input  logic [2**N_IN-1:0] expect_tbl
`endif
);

  localparam int SW = $clog2(SETTLE) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            row_fail;

  // 4-state compare so X/Z on either DUT output is reported as a failing row
`ifdef TT_EXPECT_EN
  assign row_fail = (dut_a !== dut_b) || (dut_a !== expect_tbl[vec_q]);
`else
  assign row_fail = (dut_a !== dut_b);
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    cnt_d    = cnt_q;
    fv_d     = fv_q;
    fvec_d   = fvec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_DRIVE;
          settle_d = '0;
          vec_d    = '0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          cnt_d    = '0;
          fv_d     = 1'b0;
          fvec_d   = '0;
        end
      end
      S_DRIVE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d  = S_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_SAMPLE: begin
        if (row_fail) begin
          cnt_d = cnt_q + (N_IN + 1)'(1);
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        // done/busy/pass are registered here so they line up with the DONE state cycle
        if (vec_q == '1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
        end else begin
          state_d  = S_DRIVE;
          vec_d    = vec_q + N_IN'(1);
          settle_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      fvec_q   <= fvec_d;
    end
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign fail_valid   = fv_q;
  assign fail_vec     = fvec_q;

endmodule
